// File: rtl/env_trap_ctrl.sv
// Multicycle ECALL/EBREAK/MRET controller: stalls the pipeline, updates mepc/mcause/mtvec,
// redirects fetch one cycle after sampling, and runs the halt req/ack handshake with timeout.
module env_trap_ctrl #(
  parameter int               XLEN        = 64,
  parameter int               CODE_W      = 8,
  parameter int               CNT_W       = 32,
  parameter bit               EBREAK_TRAP = 1'b0,
  parameter int               HALT_TMO    = 255,
  parameter logic [XLEN-1:0]  RESET_MTVEC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        env_op,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   gpr10,
  input  logic              mtvec_we,
  input  logic [XLEN-1:0]   mtvec_wdata,
  input  logic              halt_ack,
  output logic              stall,
  output logic              redirect_vld,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [XLEN-1:0]   mepc,
  output logic [XLEN-1:0]   mcause,
  output logic [XLEN-1:0]   mtvec,
  output logic              halt_req,
  output logic [CODE_W-1:0] halt_code,
  output logic [XLEN-1:0]   halt_pc,
  output logic              halted,
  output logic              halt_tmo,
  output logic [CNT_W-1:0]  ecall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_TRAP, S_RET, S_HALT_REQ, S_HALTED
  } state_e;

  localparam logic [1:0] OP_ECALL  = 2'b01;
  localparam logic [1:0] OP_EBREAK = 2'b10;
  localparam logic [1:0] OP_MRET   = 2'b11;

  localparam int              TMO_W       = (HALT_TMO < 2) ? 1 : $clog2(HALT_TMO);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(HALT_TMO - 1);
  localparam logic [XLEN-1:0] ALIGN_MASK  = ~(XLEN'(3));
  localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_BRK   = XLEN'(3);

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   cause_q;
  logic              redirect_vld_q;
  logic [XLEN-1:0]   redirect_pc_q;
  logic [XLEN-1:0]   mepc_q;
  logic [XLEN-1:0]   mcause_q;
  logic [XLEN-1:0]   mtvec_q;
  logic              halt_req_q;
  logic [CODE_W-1:0] halt_code_q;
  logic [XLEN-1:0]   halt_pc_q;
  logic              halted_q;
  logic              halt_tmo_q;
  logic [CNT_W-1:0]  ecall_cnt_q;
  logic [TMO_W-1:0]  tmo_q;

  logic unused_gpr_hi;
  assign unused_gpr_hi = ^gpr10[XLEN-1:CODE_W];

  // Redirect target is captured at the sample edge, so a concurrent mtvec write
  // never leaks into the redirect of the trap it coincides with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pc_q           <= '0;
      cause_q        <= '0;
      redirect_vld_q <= 1'b0;
      redirect_pc_q  <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtvec_q        <= RESET_MTVEC & ALIGN_MASK;
      halt_req_q     <= 1'b0;
      halt_code_q    <= '0;
      halt_pc_q      <= '0;
      halted_q       <= 1'b0;
      halt_tmo_q     <= 1'b0;
      ecall_cnt_q    <= '0;
      tmo_q          <= '0;
    end else begin
      redirect_vld_q <= 1'b0;
      redirect_pc_q  <= '0;
      if (mtvec_we) mtvec_q <= mtvec_wdata & ALIGN_MASK;

      case (state_q)
        S_IDLE: begin
          if (en && env_op != 2'b00) begin
            pc_q <= pc;
            if (env_op == OP_ECALL || (env_op == OP_EBREAK && EBREAK_TRAP)) begin
              state_q        <= S_TRAP;
              cause_q        <= (env_op == OP_ECALL) ? CAUSE_ECALL : CAUSE_BRK;
              redirect_vld_q <= 1'b1;
              redirect_pc_q  <= mtvec_q;
              if (env_op == OP_ECALL && ecall_cnt_q != {CNT_W{1'b1}})
                ecall_cnt_q <= ecall_cnt_q + CNT_W'(1);
            end else if (env_op == OP_EBREAK) begin
              state_q     <= S_HALT_REQ;
              halt_req_q  <= 1'b1;
              halt_code_q <= gpr10[CODE_W-1:0];
              halt_pc_q   <= pc;
              tmo_q       <= '0;
            end else if (env_op == OP_MRET) begin
              state_q        <= S_RET;
              redirect_vld_q <= 1'b1;
              redirect_pc_q  <= mepc_q;
            end
          end
        end
        S_TRAP: begin
          mepc_q   <= pc_q;
          mcause_q <= cause_q;
          state_q  <= S_IDLE;
        end
        S_RET: state_q <= S_IDLE;
        S_HALT_REQ: begin
          // An ack coinciding with the last timeout cycle wins over the timeout.
          if (halt_ack) begin
            state_q    <= S_HALTED;
            halt_req_q <= 1'b0;
            halted_q   <= 1'b1;
          end else if (tmo_q == TMO_LAST) begin
            state_q    <= S_HALTED;
            halt_req_q <= 1'b0;
            halted_q   <= 1'b1;
            halt_tmo_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        S_HALTED: state_q <= S_HALTED;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign stall        = (state_q != S_IDLE);
  assign redirect_vld = redirect_vld_q;
  assign redirect_pc  = redirect_pc_q;
  assign mepc         = mepc_q;
  assign mcause       = mcause_q;
  assign mtvec        = mtvec_q;
  assign halt_req     = halt_req_q;
  assign halt_code    = halt_code_q;
  assign halt_pc      = halt_pc_q;
  assign halted       = halted_q;
  assign halt_tmo     = halt_tmo_q;
  assign ecall_cnt    = ecall_cnt_q;

endmodule

// File: tb/tb_env_trap_ctrl.sv
// Bench for env_trap_ctrl: directed scenarios plus a randomized ECALL/MRET/mtvec stream
// checked against an architectural model of the trap CSRs.
module tb_env_trap_ctrl;
  localparam int XLEN = 64;
  localparam int CODE_W = 8;
  localparam int CNT_W = 2;
  localparam int HALT_TMO = 4;
  localparam logic [XLEN-1:0] RST_VEC = 64'h0000_0000_8000_0007;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [1:0]        env_op;
  logic [XLEN-1:0]   pc, gpr10, mtvec_wdata;
  logic              mtvec_we, halt_ack;
  logic              stall, redirect_vld, halt_req, halted, halt_tmo;
  logic [XLEN-1:0]   redirect_pc, mepc, mcause, mtvec, halt_pc;
  logic [CODE_W-1:0] halt_code;
  logic [CNT_W-1:0]  ecall_cnt;

  int checks = 0;
  int failures = 0;

  // Architectural model
  logic [XLEN-1:0] m_mtvec, m_mepc, m_mcause;
  int              m_cnt;

  env_trap_ctrl #(
    .XLEN(XLEN), .CODE_W(CODE_W), .CNT_W(CNT_W), .EBREAK_TRAP(1'b0),
    .HALT_TMO(HALT_TMO), .RESET_MTVEC(RST_VEC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .env_op(env_op), .pc(pc), .gpr10(gpr10),
    .mtvec_we(mtvec_we), .mtvec_wdata(mtvec_wdata), .halt_ack(halt_ack),
    .stall(stall), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .mepc(mepc), .mcause(mcause), .mtvec(mtvec), .halt_req(halt_req),
    .halt_code(halt_code), .halt_pc(halt_pc), .halted(halted),
    .halt_tmo(halt_tmo), .ecall_cnt(ecall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] exp_cnt();
    return (m_cnt > 3) ? CNT_W'(3) : CNT_W'(m_cnt);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; env_op = 2'b00; mtvec_we = 1'b0; halt_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    pc = '0; gpr10 = '0; mtvec_wdata = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    m_mtvec = RST_VEC & ~64'd3; m_mepc = '0; m_mcause = '0; m_cnt = 0;
    step();
  endtask

  task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] ipc, input logic [XLEN-1:0] a0);
    en = 1'b1; env_op = op; pc = ipc; gpr10 = a0;
    step();
    en = 1'b0; env_op = 2'b00;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (stall !== 1'b0 || redirect_vld !== 1'b0 || redirect_pc !== '0 || halt_req !== 1'b0 ||
        halted !== 1'b0 || halt_tmo !== 1'b0 || ecall_cnt !== '0 || mepc !== '0 || mcause !== '0) begin
      failures++;
      $display("FAIL reset_outputs: stall=%b rv=%b rpc=%h hreq=%b hlt=%b tmo=%b cnt=%0d mepc=%h mcause=%h, need all 0",
               stall, redirect_vld, redirect_pc, halt_req, halted, halt_tmo, ecall_cnt, mepc, mcause);
    end
    checks++;
    if (mtvec !== 64'h8000_0004) begin
      failures++; $display("FAIL reset_mtvec: got %h need %h", mtvec, 64'h8000_0004);
    end
  endtask

  task automatic test_ecall_mtvec_write();
    logic [XLEN-1:0] old_vec;
    old_vec = m_mtvec;
    mtvec_we = 1'b1; mtvec_wdata = 64'h8000_0103;
    issue(2'b01, 64'h8000_0010, '0);
    mtvec_we = 1'b0;
    m_mtvec = 64'h8000_0100; m_cnt++;
    checks++;
    if (redirect_vld !== 1'b1 || redirect_pc !== old_vec || stall !== 1'b1) begin
      failures++;
      $display("FAIL ecall_redirect: vld=%b pc=%h stall=%b need 1 %h 1", redirect_vld, redirect_pc, stall, old_vec);
    end
    step();
    m_mepc = 64'h8000_0010; m_mcause = 64'd11;
    checks++;
    if (mtvec !== m_mtvec || mepc !== m_mepc || mcause !== m_mcause || ecall_cnt !== exp_cnt() ||
        redirect_vld !== 1'b0 || redirect_pc !== '0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL ecall_csr: mtvec=%h mepc=%h mcause=%0d cnt=%0d vld=%b stall=%b need %h %h 11 %0d 0 0",
               mtvec, mepc, mcause, ecall_cnt, redirect_vld, stall, m_mtvec, m_mepc, exp_cnt());
    end
  endtask

  task automatic test_mret();
    issue(2'b11, 64'h1234, '0);
    checks++;
    if (redirect_vld !== 1'b1 || redirect_pc !== 64'h8000_0010) begin
      failures++; $display("FAIL mret_redirect: vld=%b pc=%h need 1 80000010", redirect_vld, redirect_pc);
    end
    step();
    checks++;
    if (redirect_vld !== 1'b0 || mepc !== m_mepc || mcause !== m_mcause || stall !== 1'b0) begin
      failures++;
      $display("FAIL mret_after: vld=%b mepc=%h mcause=%h stall=%b need 0 %h %h 0", redirect_vld, mepc, mcause, stall, m_mepc, m_mcause);
    end
  endtask

  task automatic test_random_ops();
    for (int i = 0; i < 40; i++) begin
      int kind, wr_when;
      logic [XLEN-1:0] ipc, wdata, exp_tgt;
      logic [1:0] op;
      kind = $urandom_range(0, 3);
      wr_when = $urandom_range(0, 2);
      ipc = {$urandom, $urandom} & ~64'd3;
      wdata = {$urandom, $urandom};
      if (kind == 3) begin
        // no-op cycle: either en low with an op, or en high with op none
        if ($urandom_range(0, 1) == 1) begin en = 1'b0; env_op = 2'($urandom_range(1, 3)); end
        else begin en = 1'b1; env_op = 2'b00; end
        pc = ipc;
        step();
        idle_inputs();
        checks++;
        if (redirect_vld !== 1'b0 || stall !== 1'b0 || ecall_cnt !== exp_cnt()) begin
          failures++; $display("FAIL rand_noop[%0d]: vld=%b stall=%b cnt=%0d", i, redirect_vld, stall, ecall_cnt);
        end
        continue;
      end
      op = (kind == 2) ? 2'b11 : 2'b01;
      exp_tgt = (op == 2'b01) ? m_mtvec : m_mepc;
      if (wr_when == 1) begin mtvec_we = 1'b1; mtvec_wdata = wdata; end
      issue(op, ipc, {$urandom, $urandom});
      mtvec_we = 1'b0;
      if (wr_when == 1) m_mtvec = wdata & ~64'd3;
      if (op == 2'b01) m_cnt++;
      checks++;
      if (redirect_vld !== 1'b1 || redirect_pc !== exp_tgt || stall !== 1'b1) begin
        failures++;
        $display("FAIL rand_redirect[%0d]: op=%0d vld=%b pc=%h stall=%b need 1 %h 1", i, op, redirect_vld, redirect_pc, stall, exp_tgt);
      end
      if (wr_when == 2) begin mtvec_we = 1'b1; mtvec_wdata = wdata; end
      step();
      mtvec_we = 1'b0;
      if (wr_when == 2) m_mtvec = wdata & ~64'd3;
      if (op == 2'b01) begin m_mepc = ipc; m_mcause = 64'd11; end
      checks++;
      if (redirect_vld !== 1'b0 || redirect_pc !== '0 || stall !== 1'b0 || mtvec !== m_mtvec ||
          mepc !== m_mepc || mcause !== m_mcause || ecall_cnt !== exp_cnt()) begin
        failures++;
        $display("FAIL rand_csr[%0d]: vld=%b stall=%b mtvec=%h mepc=%h mcause=%h cnt=%0d need 0 0 %h %h %h %0d",
                 i, redirect_vld, stall, mtvec, mepc, mcause, ecall_cnt, m_mtvec, m_mepc, m_mcause, exp_cnt());
      end
    end
  endtask

  task automatic test_counter_saturation();
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      issue(2'b01, 64'h100 + 64'(4 * n), '0);
      m_cnt++;
      step();
      checks++;
      if (ecall_cnt !== exp_cnt()) begin
        failures++; $display("FAIL cnt_sat[%0d]: got %0d need %0d", n, ecall_cnt, exp_cnt());
      end
    end
  endtask

  task automatic test_halt_ack();
    do_reset();
    issue(2'b10, 64'h8000_0040, 64'h100);
    checks++;
    if (halt_req !== 1'b1 || halt_code !== 8'h00 || halt_pc !== 64'h8000_0040 || stall !== 1'b1 ||
        redirect_vld !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_req_rise: req=%b code=%h hpc=%h stall=%b vld=%b hlt=%b need 1 00 80000040 1 0 0",
               halt_req, halt_code, halt_pc, stall, redirect_vld, halted);
    end
    gpr10 = 64'hFF; pc = 64'hDEAD_0000;
    step();
    step();
    checks++;
    if (halt_req !== 1'b1 || halt_code !== 8'h00 || halt_pc !== 64'h8000_0040) begin
      failures++; $display("FAIL halt_hold: req=%b code=%h hpc=%h need 1 00 80000040", halt_req, halt_code, halt_pc);
    end
    halt_ack = 1'b1;
    step();
    halt_ack = 1'b0;
    checks++;
    if (halted !== 1'b1 || halt_tmo !== 1'b0 || halt_req !== 1'b0 || stall !== 1'b1) begin
      failures++; $display("FAIL halt_acked: hlt=%b tmo=%b req=%b stall=%b need 1 0 0 1", halted, halt_tmo, halt_req, stall);
    end
  endtask

  task automatic test_halt_timeout();
    do_reset();
    issue(2'b10, 64'h8000_0080, 64'h5A);
    for (int k = 1; k < HALT_TMO; k++) begin
      step();
      checks++;
      if (halted !== 1'b0 || halt_req !== 1'b1) begin
        failures++; $display("FAIL tmo_wait[%0d]: hlt=%b req=%b need 0 1", k, halted, halt_req);
      end
    end
    step();
    checks++;
    if (halted !== 1'b1 || halt_tmo !== 1'b1 || halt_req !== 1'b0 || halt_code !== 8'h5A) begin
      failures++; $display("FAIL tmo_fire: hlt=%b tmo=%b req=%b code=%h need 1 1 0 5a", halted, halt_tmo, halt_req, halt_code);
    end
    for (int k = 0; k < 3; k++) begin
      issue(2'b01, 64'h200, '0);
      checks++;
      if (ecall_cnt !== exp_cnt() || stall !== 1'b1 || redirect_vld !== 1'b0 || halted !== 1'b1) begin
        failures++;
        $display("FAIL halted_ignore[%0d]: cnt=%0d stall=%b vld=%b hlt=%b need %0d 1 0 1", k, ecall_cnt, stall, redirect_vld, halted, exp_cnt());
      end
    end
  endtask

  task automatic test_ack_at_timeout();
    do_reset();
    issue(2'b10, 64'h8000_00C0, '0);
    step(); step(); step();
    halt_ack = 1'b1;
    step();
    halt_ack = 1'b0;
    checks++;
    if (halted !== 1'b1 || halt_tmo !== 1'b0) begin
      failures++; $display("FAIL ack_at_tmo: hlt=%b tmo=%b need 1 0", halted, halt_tmo);
    end
  endtask

  task automatic test_reset_mid_halt();
    do_reset();
    mtvec_we = 1'b1; mtvec_wdata = 64'h4000;
    step();
    mtvec_we = 1'b0;
    issue(2'b10, 64'h8000_0100, 64'h33);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || halt_req !== 1'b0 || halt_code !== '0 || halt_pc !== '0 || halted !== 1'b0 ||
        redirect_vld !== 1'b0 || mtvec !== 64'h8000_0004) begin
      failures++;
      $display("FAIL async_reset: stall=%b req=%b code=%h hpc=%h hlt=%b vld=%b mtvec=%h need 0 0 0 0 0 0 80000004",
               stall, halt_req, halt_code, halt_pc, halted, redirect_vld, mtvec);
    end
    step();
    rst_n = 1'b1;
    m_mtvec = 64'h8000_0004; m_mepc = '0; m_mcause = '0; m_cnt = 0;
    step();
    issue(2'b01, 64'h8000_0200, '0);
    checks++;
    if (redirect_vld !== 1'b1 || redirect_pc !== m_mtvec) begin
      failures++; $display("FAIL post_reset_ecall: vld=%b pc=%h need 1 %h", redirect_vld, redirect_pc, m_mtvec);
    end
    step();
    checks++;
    if (mepc !== 64'h8000_0200 || mcause !== 64'd11 || ecall_cnt !== 2'd1) begin
      failures++; $display("FAIL post_reset_csr: mepc=%h mcause=%0d cnt=%0d need 80000200 11 1", mepc, mcause, ecall_cnt);
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    pc = '0; gpr10 = '0; mtvec_wdata = '0;
    test_reset();
    test_ecall_mtvec_write();
    test_mret();
    test_random_ops();
    test_counter_saturation();
    test_halt_ack();
    test_halt_timeout();
    test_ack_at_timeout();
    test_reset_mid_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
